// File: rtl/pipeline_hazard_controller.sv
// pipeline_hazard_controller
//
// Central stall/flush scheduler for a 5-stage MIPS pipeline. It watches the
// IF/ID, ID/EX and EX/MEM pipeline registers and drives their write-enables
// and flushes, plus PC write and PC source. It handles three events:
//   - load-use hazards
//   - taken branches resolved in MEM
//   - multi-cycle mul/div operations held in EX
// Every control output is combinational from the current state and inputs,
// so it gates the pipeline registers at the next posedge Clk.
//
// Parameters
//   MULDIV_TIMEOUT  maximum BUSY cycles before the mul/div is aborted
//   CNT_W           width of the saturating statistics counters
//
// Ports
//   Clk, Reset                        clock, synchronous active-high reset
//   IFID_RegisterRs/Rt, IFID_UsesRt   source operands of the ID instruction
//   IDEX_MemRead, IDEX_RegisterRt     load in EX and its destination
//   IDEX_MulDiv, MulDiv_Done          mul/div in EX, and result valid
//   EXMEM_Branch, EXMEM_ALUZero       branch in MEM; taken when both are high
//   PCWrite, IFIDWrite, IDEXWrite     register write-enables (hold when low)
//   IFIDFlush, IDEXFlush, EXMEMFlush  load a bubble into the register
//   PCSrc                             select the branch target
//   MulDivStart, MulDivAbort          single-cycle pulses to the mul/div unit
//   Error                             sticky, set on mul/div timeout
//   StallCount, FlushCount            saturating event counters
//
// State table
//   state | meaning
//   RUN   | normal issue; load-use, branch and mul/div start are detected
//   BUSY  | mul/div in EX; front of the pipe held until Done or timeout

module pipeline_hazard_controller #(
    parameter int MULDIV_TIMEOUT = 64,
    parameter int CNT_W          = 16
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic [4:0]       IFID_RegisterRs,
    input  logic [4:0]       IFID_RegisterRt,
    input  logic             IFID_UsesRt,
    input  logic             IDEX_MemRead,
    input  logic [4:0]       IDEX_RegisterRt,
    input  logic             IDEX_MulDiv,
    input  logic             MulDiv_Done,
    input  logic             EXMEM_Branch,
    input  logic             EXMEM_ALUZero,
    output logic             PCWrite,
    output logic             IFIDWrite,
    output logic             IDEXWrite,
    output logic             IFIDFlush,
    output logic             IDEXFlush,
    output logic             EXMEMFlush,
    output logic             PCSrc,
    output logic             MulDivStart,
    output logic             MulDivAbort,
    output logic             Error,
    output logic [CNT_W-1:0] StallCount,
    output logic [CNT_W-1:0] FlushCount
);

    localparam int WAIT_W = (MULDIV_TIMEOUT > 1) ? $clog2(MULDIV_TIMEOUT) : 1;
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MULDIV_TIMEOUT - 1);

    typedef enum logic {
        RUN  = 1'b0,
        BUSY = 1'b1
    } state_t;

    state_t            state;
    state_t            state_next;
    logic [WAIT_W-1:0] wait_cnt;
    logic [WAIT_W-1:0] wait_next;
    logic              error_set;
    logic              branch_taken;
    logic              load_use;
    logic              timeout;

    assign branch_taken = EXMEM_Branch & EXMEM_ALUZero;
    assign timeout      = (wait_cnt == WAIT_LAST);

    // Rt = 0 is never a real load destination, so it cannot create a hazard.
    assign load_use = IDEX_MemRead && (IDEX_RegisterRt != 5'd0) &&
                      ((IDEX_RegisterRt == IFID_RegisterRs) ||
                       (IFID_UsesRt && (IDEX_RegisterRt == IFID_RegisterRt)));

    // State register, wait counter, sticky error and statistics.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state      <= RUN;
            wait_cnt   <= '0;
            Error      <= 1'b0;
            StallCount <= '0;
            FlushCount <= '0;
        end else begin
            state    <= state_next;
            wait_cnt <= wait_next;
            if (error_set) begin
                Error <= 1'b1;
            end
            if (!PCWrite && (StallCount != '1)) begin
                StallCount <= StallCount + 1'b1;
            end
            if (branch_taken && (FlushCount != '1)) begin
                FlushCount <= FlushCount + 1'b1;
            end
        end
    end

    // Next-state logic.
    always_comb begin
        state_next = state;
        wait_next  = wait_cnt;
        error_set  = 1'b0;
        unique case (state)
            RUN: begin
                if (!branch_taken && IDEX_MulDiv) begin
                    state_next = BUSY;
                    wait_next  = '0;
                end
            end
            BUSY: begin
                // Done is tested before timeout so a late result is never lost.
                if (branch_taken || MulDiv_Done) begin
                    state_next = RUN;
                end else if (timeout) begin
                    state_next = RUN;
                    error_set  = 1'b1;
                end else begin
                    wait_next = wait_cnt + 1'b1;
                end
            end
            default: state_next = RUN;
        endcase
    end

    // Output logic. During Reset everything stays at the default values.
    always_comb begin
        PCWrite     = 1'b1;
        IFIDWrite   = 1'b1;
        IDEXWrite   = 1'b1;
        IFIDFlush   = 1'b0;
        IDEXFlush   = 1'b0;
        EXMEMFlush  = 1'b0;
        PCSrc       = 1'b0;
        MulDivStart = 1'b0;
        MulDivAbort = 1'b0;
        if (!Reset) begin
            if (branch_taken) begin
                PCSrc      = 1'b1;
                IFIDFlush  = 1'b1;
                IDEXFlush  = 1'b1;
                EXMEMFlush = 1'b1;
                // A mul/div behind a taken branch is on the wrong path.
                if ((state == BUSY) || IDEX_MulDiv) begin
                    MulDivAbort = 1'b1;
                end
            end else if (state == RUN) begin
                if (IDEX_MulDiv) begin
                    MulDivStart = 1'b1;
                    PCWrite     = 1'b0;
                    IFIDWrite   = 1'b0;
                    IDEXWrite   = 1'b0;
                    EXMEMFlush  = 1'b1;
                end else if (load_use) begin
                    PCWrite   = 1'b0;
                    IFIDWrite = 1'b0;
                    IDEXFlush = 1'b1;
                end
            end else if (!MulDiv_Done) begin
                // Bubbles go into EX/MEM while the op is still running; on
                // timeout the stage is released but the op is still dropped.
                EXMEMFlush = 1'b1;
                if (timeout) begin
                    MulDivAbort = 1'b1;
                end else begin
                    PCWrite   = 1'b0;
                    IFIDWrite = 1'b0;
                    IDEXWrite = 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_pipeline_hazard_controller.sv
module tb_pipeline_hazard_controller;

    localparam int CNT_W = 4;

    // {PCWrite,IFIDWrite,IDEXWrite,IFIDFlush,IDEXFlush,EXMEMFlush,PCSrc,MulDivStart,MulDivAbort}
    localparam logic [8:0] C_DEF   = 9'b111_000_0_0_0;
    localparam logic [8:0] C_LU    = 9'b001_010_0_0_0;
    localparam logic [8:0] C_BR    = 9'b111_111_1_0_0;
    localparam logic [8:0] C_BRA   = 9'b111_111_1_0_1;
    localparam logic [8:0] C_START = 9'b000_001_0_1_0;
    localparam logic [8:0] C_HOLD  = 9'b000_001_0_0_0;
    localparam logic [8:0] C_TO    = 9'b111_001_0_0_1;

    logic             Clk = 1'b0;
    logic             Reset;
    logic [4:0]       IFID_RegisterRs, IFID_RegisterRt, IDEX_RegisterRt;
    logic             IFID_UsesRt, IDEX_MemRead, IDEX_MulDiv, MulDiv_Done;
    logic             EXMEM_Branch, EXMEM_ALUZero;
    logic             PCWrite, IFIDWrite, IDEXWrite;
    logic             IFIDFlush, IDEXFlush, EXMEMFlush;
    logic             PCSrc, MulDivStart, MulDivAbort, Error;
    logic [CNT_W-1:0] StallCount, FlushCount;
    logic [8:0]       ctrl;

    int checks = 0;
    int errors = 0;

    pipeline_hazard_controller #(.MULDIV_TIMEOUT(8), .CNT_W(CNT_W)) dut (
        .Clk(Clk), .Reset(Reset),
        .IFID_RegisterRs(IFID_RegisterRs), .IFID_RegisterRt(IFID_RegisterRt),
        .IFID_UsesRt(IFID_UsesRt), .IDEX_MemRead(IDEX_MemRead),
        .IDEX_RegisterRt(IDEX_RegisterRt), .IDEX_MulDiv(IDEX_MulDiv),
        .MulDiv_Done(MulDiv_Done), .EXMEM_Branch(EXMEM_Branch),
        .EXMEM_ALUZero(EXMEM_ALUZero), .PCWrite(PCWrite), .IFIDWrite(IFIDWrite),
        .IDEXWrite(IDEXWrite), .IFIDFlush(IFIDFlush), .IDEXFlush(IDEXFlush),
        .EXMEMFlush(EXMEMFlush), .PCSrc(PCSrc), .MulDivStart(MulDivStart),
        .MulDivAbort(MulDivAbort), .Error(Error), .StallCount(StallCount),
        .FlushCount(FlushCount)
    );

    always #5 Clk = ~Clk;

    assign ctrl = {PCWrite, IFIDWrite, IDEXWrite, IFIDFlush, IDEXFlush,
                   EXMEMFlush, PCSrc, MulDivStart, MulDivAbort};

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Outputs are sampled 1 ns after inputs change, well away from posedge.
    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic idle();
        IFID_RegisterRs = 5'd0; IFID_RegisterRt = 5'd0; IFID_UsesRt = 1'b0;
        IDEX_MemRead = 1'b0; IDEX_RegisterRt = 5'd0; IDEX_MulDiv = 1'b0;
        MulDiv_Done = 1'b0; EXMEM_Branch = 1'b0; EXMEM_ALUZero = 1'b0;
    endtask

    task automatic do_reset();
        Reset = 1'b1;
        tick();
        Reset = 1'b0;
        #1;
    endtask

    initial begin
        idle();
        // Reset with a live load-use pattern: outputs must still be default.
        Reset = 1'b1;
        IDEX_MemRead = 1'b1; IDEX_RegisterRt = 5'd8; IFID_RegisterRs = 5'd8;
        tick(); tick();
        chk("reset_ctrl", 16'(ctrl), 16'(C_DEF));
        chk("reset_error", 16'(Error), 16'd0);
        chk("reset_stall", 16'(StallCount), 16'd0);
        chk("reset_flush", 16'(FlushCount), 16'd0);

        // Load-use on Rs: one stall cycle, bubble clears MemRead.
        Reset = 1'b0; #1;
        chk("lu_rs", 16'(ctrl), 16'(C_LU));
        tick();
        IDEX_MemRead = 1'b0; #1;
        chk("lu_after", 16'(ctrl), 16'(C_DEF));
        chk("lu_stall_cnt", 16'(StallCount), 16'd1);
        // Rt = 0 never hazards.
        IDEX_MemRead = 1'b1; IDEX_RegisterRt = 5'd0; IFID_RegisterRs = 5'd0; #1;
        chk("lu_rt0", 16'(ctrl), 16'(C_DEF));
        // Hazard through Rt only when the ID instruction reads Rt.
        IDEX_RegisterRt = 5'd9; IFID_RegisterRt = 5'd9; IFID_RegisterRs = 5'd3;
        IFID_UsesRt = 1'b1; #1;
        chk("lu_rt_used", 16'(ctrl), 16'(C_LU));
        IFID_UsesRt = 1'b0; #1;
        chk("lu_rt_unused", 16'(ctrl), 16'(C_DEF));
        idle(); tick();
        chk("lu_stall_hold", 16'(StallCount), 16'd1);

        // Branch not taken, then taken.
        EXMEM_Branch = 1'b1; #1;
        chk("br_not_taken", 16'(ctrl), 16'(C_DEF));
        EXMEM_ALUZero = 1'b1; #1;
        chk("br_taken", 16'(ctrl), 16'(C_BR));
        tick(); idle(); #1;
        chk("br_after", 16'(ctrl), 16'(C_DEF));
        chk("br_flush_cnt", 16'(FlushCount), 16'd1);

        // Mul/div, Done after 5 BUSY cycles; load-use ignored while BUSY.
        IDEX_MulDiv = 1'b1; #1;
        chk("md_start", 16'(ctrl), 16'(C_START));
        tick();
        for (int i = 1; i <= 5; i++) begin
            IDEX_MemRead = (i == 3); IDEX_RegisterRt = 5'd8; IFID_RegisterRs = 5'd8; #1;
            chk($sformatf("md_hold%0d", i), 16'(ctrl), 16'(C_HOLD));
            tick();
        end
        IDEX_MemRead = 1'b0;
        MulDiv_Done = 1'b1; #1;
        chk("md_done", 16'(ctrl), 16'(C_DEF));
        tick(); idle(); #1;
        chk("md_run_after", 16'(ctrl), 16'(C_DEF));
        chk("md_stall_cnt", 16'(StallCount), 16'd7);
        chk("md_error", 16'(Error), 16'd0);

        // Timeout with MULDIV_TIMEOUT = 8.
        do_reset();
        IDEX_MulDiv = 1'b1; #1;
        chk("to_start", 16'(ctrl), 16'(C_START));
        tick();
        for (int i = 1; i <= 7; i++) begin
            chk($sformatf("to_hold%0d", i), 16'(ctrl), 16'(C_HOLD));
            tick();
        end
        chk("to_abort", 16'(ctrl), 16'(C_TO));
        tick();
        chk("to_error", 16'(Error), 16'd1);
        chk("to_stall_cnt", 16'(StallCount), 16'd8);
        IDEX_MulDiv = 1'b0; #1;
        chk("to_run", 16'(ctrl), 16'(C_DEF));
        tick(); tick();
        chk("to_error_sticky", 16'(Error), 16'd1);

        // Reset mid-BUSY: no abort, back to RUN with everything cleared.
        IDEX_MulDiv = 1'b1; #1;
        tick(); tick();
        chk("rb_hold", 16'(ctrl), 16'(C_HOLD));
        Reset = 1'b1; #1;
        chk("rb_in_reset", 16'(ctrl), 16'(C_DEF));
        tick();
        Reset = 1'b0; IDEX_MulDiv = 1'b0; #1;
        chk("rb_run", 16'(ctrl), 16'(C_DEF));
        chk("rb_error", 16'(Error), 16'd0);
        chk("rb_stall", 16'(StallCount), 16'd0);

        // Done in the timeout cycle: Done wins, no Error.
        IDEX_MulDiv = 1'b1; #1;
        tick();
        for (int i = 1; i <= 7; i++) tick();
        MulDiv_Done = 1'b1; #1;
        chk("dt_done_wins", 16'(ctrl), 16'(C_DEF));
        tick(); idle(); #1;
        chk("dt_run", 16'(ctrl), 16'(C_DEF));
        chk("dt_error", 16'(Error), 16'd0);
        chk("dt_stall_cnt", 16'(StallCount), 16'd8);

        // Branch on the mul/div start cycle.
        IDEX_MulDiv = 1'b1; EXMEM_Branch = 1'b1; EXMEM_ALUZero = 1'b1; #1;
        chk("bs_abort", 16'(ctrl), 16'(C_BRA));
        tick(); idle(); #1;
        chk("bs_run", 16'(ctrl), 16'(C_DEF));

        // Branch in BUSY cycle 3.
        IDEX_MulDiv = 1'b1; #1;
        tick(); tick(); tick();
        EXMEM_Branch = 1'b1; EXMEM_ALUZero = 1'b1; #1;
        chk("bb_abort", 16'(ctrl), 16'(C_BRA));
        tick(); idle(); #1;
        chk("bb_run", 16'(ctrl), 16'(C_DEF));

        // Branch and Done together: branch wins with abort.
        IDEX_MulDiv = 1'b1; #1;
        tick();
        MulDiv_Done = 1'b1; EXMEM_Branch = 1'b1; EXMEM_ALUZero = 1'b1; #1;
        chk("bd_abort", 16'(ctrl), 16'(C_BRA));
        tick(); idle(); #1;
        chk("bd_run", 16'(ctrl), 16'(C_DEF));
        chk("bd_stall_cnt", 16'(StallCount), 16'd12);
        chk("bd_flush_cnt", 16'(FlushCount), 16'd3);

        // FlushCount saturates at all-ones.
        do_reset();
        EXMEM_Branch = 1'b1; EXMEM_ALUZero = 1'b1;
        for (int i = 0; i < 20; i++) tick();
        chk("sat_flush", 16'(FlushCount), 16'hF);
        chk("sat_stall", 16'(StallCount), 16'd0);
        idle();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
